// File: rtl/lfsr_chk_pkg.sv
// Shared types and helpers for the LFSR period checker.
package lfsr_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int max_period(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/lfsr_seen_map.sv
// One bit per possible LFSR word, recording which words have been seen.
// clr_set reloads the whole map with only bit[addr] set in a single cycle.
module lfsr_seen_map #(
    parameter int BITWIDTH = 5
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                clr_set,
    input  logic                set,
    input  logic [BITWIDTH-1:0] addr,
    output logic                hit
);
    localparam int DEPTH = 1 << BITWIDTH;

    logic [DEPTH-1:0] r_bits;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_bits <= '0;
        end else if (clr_set) begin
            r_bits <= DEPTH'(1) << addr;
        end else if (set) begin
            r_bits[addr] <= 1'b1;
        end
    end

    assign hit = r_bits[addr];

endmodule

// File: rtl/lfsr_period_checker.sv
// Measures the period of an LFSR output stream starting from its first sample,
// flagging the all-zero lock-up state and early non-seed repeats.
module lfsr_period_checker
    import lfsr_chk_pkg::*;
#(
    parameter int BITWIDTH = 5
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic                start,
    input  logic                in_valid,
    input  logic [BITWIDTH-1:0] lfsr_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                err_zero,
    output logic                err_dup,
    output logic [BITWIDTH:0]   period
);
    localparam logic [BITWIDTH:0] MAX_PERIOD = (BITWIDTH+1)'(max_period(BITWIDTH));

    state_t              r_state;
    state_t              w_next;
    logic [BITWIDTH-1:0] r_seed;
    logic [BITWIDTH:0]   r_count;
    logic [BITWIDTH:0]   r_period;
    logic                r_done;
    logic                r_pass;
    logic                r_err_zero;
    logic                r_err_dup;

    logic w_accept;
    logic w_run_smp;
    logic w_zero;
    logic w_is_seed;
    logic w_hit;
    logic w_sat;
    logic w_run_stop;
    logic w_finish;

    assign w_accept   = (r_state != RUN) && start && in_valid;
    assign w_run_smp  = (r_state == RUN) && in_valid;
    assign w_zero     = (lfsr_in == '0);
    assign w_is_seed  = (lfsr_in == r_seed);
    // Unreachable with a consistent map; guards the counter against wrap.
    assign w_sat      = (r_count >= MAX_PERIOD);
    assign w_run_stop = w_run_smp && (w_zero || w_is_seed || w_hit || w_sat);
    assign w_finish   = (w_accept && w_zero) || w_run_stop;

    lfsr_seen_map #(
        .BITWIDTH(BITWIDTH)
    ) u_seen_map (
        .clk     (clk),
        .arst_n  (arst_n),
        .clr_set (w_accept),
        .set     (w_run_smp && !w_run_stop),
        .addr    (lfsr_in),
        .hit     (w_hit)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RUN:     if (w_run_stop) w_next = DONE;
            default: if (w_accept)   w_next = w_zero ? DONE : RUN;
        endcase
    end

    always_comb begin
        busy     = (r_state == RUN);
        done     = r_done;
        pass     = r_pass;
        err_zero = r_err_zero;
        err_dup  = r_err_dup;
        period   = r_period;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_seed     <= '0;
            r_count    <= '0;
            r_period   <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_zero <= 1'b0;
            r_err_dup  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_accept) begin
                r_seed     <= lfsr_in;
                r_count    <= (BITWIDTH+1)'(1);
                r_period   <= '0;
                r_pass     <= 1'b0;
                r_err_zero <= w_zero;
                r_err_dup  <= 1'b0;
            end else if (w_run_smp) begin
                if (w_zero) begin
                    r_err_zero <= 1'b1;
                    r_period   <= r_count;
                end else if (w_is_seed) begin
                    r_period <= r_count;
                    r_pass   <= (r_count == MAX_PERIOD);
                end else if (w_hit || w_sat) begin
                    r_err_dup <= 1'b1;
                    r_period  <= r_count;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Directed bench for lfsr_period_checker with BITWIDTH=5.
module tb_lfsr_period_checker;
    localparam int BW = 5;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] lfsr_in = '0;
    logic          busy, done, pass, err_zero, err_dup;
    logic [BW:0]   period;

    int checks = 0;
    int failures = 0;

    lfsr_period_checker #(.BITWIDTH(BW)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .in_valid(in_valid),
        .lfsr_in(lfsr_in), .busy(busy), .done(done), .pass(pass),
        .err_zero(err_zero), .err_dup(err_dup), .period(period)
    );

    always #5 clk = ~clk;

    // Galois LFSR for x^5+x^3+1, right-shifting.
    function automatic logic [BW-1:0] lfsr_next(input logic [BW-1:0] s);
        return s[0] ? ((s >> 1) ^ 5'h14) : (s >> 1);
    endfunction

    task automatic drive(input logic [BW-1:0] v, input logic vld, input logic st);
        lfsr_in = v; in_valid = vld; start = st;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic e_done, input logic e_pass,
                                input logic e_zero, input logic e_dup, input logic [BW:0] e_per);
        checks++; if (done !== e_done) begin failures++; $display("FAIL %s_done got=%0b exp=%0b", tag, done, e_done); end
        checks++; if (pass !== e_pass) begin failures++; $display("FAIL %s_pass got=%0b exp=%0b", tag, pass, e_pass); end
        checks++; if (err_zero !== e_zero) begin failures++; $display("FAIL %s_err_zero got=%0b exp=%0b", tag, err_zero, e_zero); end
        checks++; if (err_dup !== e_dup) begin failures++; $display("FAIL %s_err_dup got=%0b exp=%0b", tag, err_dup, e_dup); end
        checks++; if (period !== e_per) begin failures++; $display("FAIL %s_period got=%0d exp=%0d", tag, period, e_per); end
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        check_result("reset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        arst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Full 31-state run from seed 1, optionally with idle cycles inserted.
    task automatic test_full(input string tag, input bit gaps);
        logic [BW-1:0] s;
        bit busy_ok, done_early;
        busy_ok = 1'b1; done_early = 1'b0;
        s = 5'd1;
        drive(s, 1'b1, 1'b1);
        checks++; if (err_dup !== 1'b0 || period !== '0) begin
            failures++; $display("FAIL %s_start_clear dup=%0b period=%0d exp dup=0 period=0", tag, err_dup, period);
        end
        for (int i = 1; i < 31; i++) begin
            s = lfsr_next(s);
            drive(s, 1'b1, 1'b0);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done !== 1'b0) done_early = 1'b1;
            if (gaps && (i == 7 || i == 13 || i == 20 || i == 26)) begin
                drive('0, 1'b0, 1'b0);
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
        end
        checks++; if (!busy_ok) begin failures++; $display("FAIL %s_busy got=0 exp=1 during run", tag); end
        checks++; if (done_early) begin failures++; $display("FAIL %s_done_early got=1 exp=0", tag); end
        s = lfsr_next(s);
        drive(s, 1'b1, 1'b0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_busy_end got=%0b exp=0", tag, busy); end
        check_result(tag, 1'b1, 1'b1, 1'b0, 1'b0, 6'd31);
        drive('0, 1'b0, 1'b0);
        check_result({tag, "_hold"}, 1'b0, 1'b1, 1'b0, 1'b0, 6'd31);
    endtask

    task automatic test_zero_seed();
        drive('0, 1'b1, 1'b1);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%0b exp=0", busy); end
        check_result("zero", 1'b1, 1'b0, 1'b1, 1'b0, '0);
        drive('0, 1'b0, 1'b0);
        check_result("zero_hold", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_short_cycle();
        drive(5'd1, 1'b1, 1'b1);
        drive(5'd2, 1'b1, 1'b0);
        drive(5'd3, 1'b1, 1'b0);
        drive(5'd4, 1'b1, 1'b1);  // start during RUN is ignored
        drive(5'd5, 1'b1, 1'b0);
        drive(5'd6, 1'b1, 1'b0);
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL short_running done=%0b busy=%0b exp done=0 busy=1", done, busy);
        end
        drive(5'd1, 1'b1, 1'b0);
        check_result("short", 1'b1, 1'b0, 1'b0, 1'b0, 6'd6);
    endtask

    task automatic test_dup();
        drive(5'd3, 1'b1, 1'b1);
        drive(5'd5, 1'b1, 1'b0);
        drive(5'd7, 1'b1, 1'b0);
        drive(5'd5, 1'b1, 1'b0);
        check_result("dup", 1'b1, 1'b0, 1'b0, 1'b1, 6'd3);
        drive('0, 1'b0, 1'b0);
        test_full("after_dup", 1'b0);
    endtask

    task automatic test_async_reset();
        logic [BW-1:0] s;
        bit done_seen;
        done_seen = 1'b0;
        s = 5'd1;
        drive(s, 1'b1, 1'b1);
        for (int i = 1; i < 10; i++) begin
            s = lfsr_next(s);
            drive(s, 1'b1, 1'b0);
        end
        #2 arst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%0b exp=0", busy); end
        check_result("areset", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk); #3;
        arst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = lfsr_next(s);
            drive(s, 1'b1, 1'b0);
            if (done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
        end
        checks++; if (done_seen) begin failures++; $display("FAIL areset_idle done=%0b busy=%0b exp 0 0", done, busy); end
        test_full("after_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_full("full", 1'b0);
        test_zero_seed();
        test_short_cycle();
        test_dup();
        test_full("gaps", 1'b1);
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
